branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Sequential branch-resolution controller between decode, the ALU and the PC/fetch stage of the RV32 core. Accepts one conditional branch at a time from decode, stalls the front end until the ALU publishes compare flags, evaluates the RV32I branch condition, and on a taken branch redirects the PC and flushes the fetch/decode stages for a fixed number of cycles. Also keeps wrap-around branch/taken counters and a sticky timeout error.

## Interface
- FLUSH_CYCLES, 2: cycles `flush` is held after a taken branch (1..15)
- WAIT_TIMEOUT, 8: max cycles in WAIT_ALU before abort (1..255)
- CNT_W, 16: width of statistics counters
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- br_valid  in  1  decode presents a branch
- br_type  in  3  b_t encoding: NONE=0, BEQ=1, BNE=2, BLT=3, BGE=4, BLTU=5, BGEU=6
- br_target  in  32  taken target address
- br_ready  out  1  controller can accept a branch
- alu_valid  in  1  ALU flags valid for the accepted branch's compare (rs1 - rs2)
- ALU_neg_flag, ALU_zero_flag, ALU_overflow_flag, ALU_borrow_flag  in  1 each  ALU compare flags
- stall  out  1  freeze PC and decode
- flush  out  1  invalidate fetch/decode
- redirect_valid  out  1  one-cycle pulse: load PC from redirect_pc
- redirect_pc  out  32  latched target
- resolved  out  1  one-cycle pulse when a branch finishes (taken, not taken or aborted)
- b_taken  out  1  outcome of last resolved branch
- timeout_err  out  1  sticky; set on WAIT_TIMEOUT expiry
- branch_cnt, taken_cnt  out  CNT_W  resolved / taken counts, wrap at 2^CNT_W

## Operation
- States: IDLE, WAIT_ALU, FLUSH.
- IDLE: br_ready=1. br_valid with br_type≠NONE → latch type and target, clear timeout counter, go WAIT_ALU. br_type=NONE or unused code (7) is consumed with no effect.
- WAIT_ALU: br_ready=0, stall=1. Timeout counter increments each cycle without alu_valid.
  - alu_valid: evaluate condition; resolved=1, branch_cnt+1, b_taken=outcome. Taken → redirect_valid=1, taken_cnt+1, go FLUSH. Not taken → IDLE.
  - counter reaches WAIT_TIMEOUT with no alu_valid: timeout_err=1, resolved=1, b_taken=0, branch_cnt+1, go IDLE.
  - alu_valid on the timeout cycle: alu_valid wins; no error.
- Conditions (correct RISC-V semantics; signed uses neg^ovf, equality counts as ≥): BEQ zero; BNE !zero; BLT neg^ovf; BGE !(neg^ovf); BLTU borrow; BGEU !borrow.
- FLUSH: flush=1, stall=0, br_ready=0 for exactly FLUSH_CYCLES cycles, then IDLE.
- redirect_valid and resolved are registered one-cycle pulses asserted the cycle after alu_valid is sampled.

## Timing
- Reset (async): state IDLE; br_ready=1; stall, flush, redirect_valid, resolved, b_taken, timeout_err=0; redirect_pc=0; counters=0. Reset mid-branch discards it.
- Acceptance at edge N (br_valid&&br_ready) → stall=1 from cycle N+1.
- alu_valid sampled at edge M → resolved/redirect_valid high in cycle M+1; not taken: br_ready=1, stall=0 in M+1. Taken: flush high M+1..M+FLUSH_CYCLES, br_ready=1 at M+FLUSH_CYCLES+1.
- alu_valid in IDLE or FLUSH is ignored (stale flags). br_valid while br_ready=0 is ignored; decode must hold it.
- Counters wrap to 0 without saturation; both may increment in the same cycle.
- Back-to-back branches: minimum spacing is 2 cycles not taken, FLUSH_CYCLES+2 taken.

## Structure
- Shared package `branch_pkg`: b_t enum (3-bit, values above), state typedef, default FLUSH_CYCLES/WAIT_TIMEOUT constants; used by decode and core top.
- Sub-module `branch_cond`: combinational (type, neg, zero, ovf, borrow) → taken; unit-testable on its own. Controller holds FSM, latches, counters.

## Test plan
- BEQ, alu_valid with zero=1 two cycles after accept → stall 2 cycles, redirect_valid pulse, redirect_pc=br_target, flush exactly FLUSH_CYCLES, taken_cnt=1.
- BLT with neg=1, ovf=1 (positive result overflowed) → not taken, resolved pulse, b_taken=0, no flush; BGE same flags → taken.
- BGE with zero=1, neg=0 → taken; BGEU borrow=0 → taken; BLTU borrow=1 → taken.
- No alu_valid for WAIT_TIMEOUT=8 cycles → timeout_err=1 sticky, b_taken=0, br_ready back high; alu_valid on the 8th cycle instead → no error.
- alu_valid pulsed during IDLE and FLUSH → no state change, no counter change; br_type=NONE → br_ready stays 1, counters unchanged.
- Assert rst mid-WAIT_ALU and mid-FLUSH → all outputs to reset values immediately (async), counters 0; 2^CNT_W resolves → branch_cnt wraps to 0.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared types and defaults for branch resolution.
//   b_t      - 3-bit conditional branch type as encoded by decode
//   state_t  - controller FSM states
//   *Def     - default controller parameters
//   is_cond_branch() - true for the six RV32I conditional branch codes
package branch_pkg;

  typedef enum logic [2:0] {
    BrNone = 3'd0,
    BrBeq  = 3'd1,
    BrBne  = 3'd2,
    BrBlt  = 3'd3,
    BrBge  = 3'd4,
    BrBltu = 3'd5,
    BrBgeu = 3'd6
  } b_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAlu,
    StFlush
  } state_t;

  localparam int unsigned FlushCyclesDef = 2;
  localparam int unsigned WaitTimeoutDef = 8;
  localparam int unsigned CntWDef        = 16;

  // Code 0 (NONE) and the unused code 7 are not branches.
  function automatic logic is_cond_branch(logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd6);
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: decode/ALU/fetch side signals of the branch controller.
//   master - decode + ALU side: drives the branch request and compare flags
//   slave  - controller side: drives handshake, front-end control, result, stats
interface branch_ctrl_if
  import branch_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef
) ();

  logic             br_valid;
  logic [2:0]       br_type;
  logic [31:0]      br_target;
  logic             br_ready;
  logic             alu_valid;
  logic             ALU_neg_flag;
  logic             ALU_zero_flag;
  logic             ALU_overflow_flag;
  logic             ALU_borrow_flag;
  logic             stall;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             resolved;
  logic             b_taken;
  logic             timeout_err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output br_valid, br_type, br_target, alu_valid,
           ALU_neg_flag, ALU_zero_flag, ALU_overflow_flag, ALU_borrow_flag,
    input  br_ready, stall, flush, redirect_valid, redirect_pc, resolved, b_taken,
           timeout_err, branch_cnt, taken_cnt
  );

  modport slave (
    input  br_valid, br_type, br_target, alu_valid,
           ALU_neg_flag, ALU_zero_flag, ALU_overflow_flag, ALU_borrow_flag,
    output br_ready, stall, flush, redirect_valid, redirect_pc, resolved, b_taken,
           timeout_err, branch_cnt, taken_cnt
  );

endinterface

// File: rtl/branch_cond.sv
// branch_cond: combinational RV32I branch condition from the flags of rs1 - rs2.
//   br_type       - branch kind (b_t)
//   neg/zero/ovf/borrow - ALU compare flags
//   taken         - branch condition holds; 0 for NONE/unused codes
module branch_cond
  import branch_pkg::*;
(
  input  b_t   br_type,
  input  logic neg,
  input  logic zero,
  input  logic ovf,
  input  logic borrow,
  output logic taken
);

  logic signed_lt;

  // Signed less-than must correct the sign bit for overflow.
  assign signed_lt = neg ^ ovf;

  always_comb begin
    taken = 1'b0;
    unique case (br_type)
      BrBeq:   taken = zero;
      BrBne:   taken = ~zero;
      BrBlt:   taken = signed_lt;
      BrBge:   taken = ~signed_lt;
      BrBltu:  taken = borrow;
      BrBgeu:  taken = ~borrow;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: sequential branch resolution between decode, ALU and fetch.
//   clk, rst - core clock; asynchronous active-high reset
//   bus      - branch_ctrl_if slave: branch request/ready, ALU flags,
//              stall/flush/redirect to the front end, result pulse and statistics
// One branch in flight: accept in IDLE, stall in WAIT_ALU until flags arrive or
// the wait times out, then hold flush for FLUSH_CYCLES after a taken branch.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FlushCyclesDef,
  parameter int unsigned WAIT_TIMEOUT = WaitTimeoutDef,
  parameter int unsigned CNT_W        = CntWDef
) (
  input logic        clk,
  input logic        rst,
  branch_ctrl_if.slave bus
);

  localparam logic [7:0] TmoLast   = 8'(WAIT_TIMEOUT - 1);
  localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  b_t               type_q, type_d;
  logic [31:0]      target_q, target_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             resolved_q, resolved_d;
  logic             redirect_q, redirect_d;
  logic             b_taken_q, b_taken_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             cond_taken;

  branch_cond u_branch_cond (
    .br_type (type_q),
    .neg     (bus.ALU_neg_flag),
    .zero    (bus.ALU_zero_flag),
    .ovf     (bus.ALU_overflow_flag),
    .borrow  (bus.ALU_borrow_flag),
    .taken   (cond_taken)
  );

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    target_d      = target_q;
    tmo_cnt_d     = tmo_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    resolved_d    = 1'b0;
    redirect_d    = 1'b0;
    b_taken_d     = b_taken_q;
    timeout_err_d = timeout_err_q;
    branch_cnt_d  = branch_cnt_q;
    taken_cnt_d   = taken_cnt_q;

    unique case (state_q)
      StIdle: begin
        // NONE and code 7 are consumed silently since br_ready is high.
        if (bus.br_valid && is_cond_branch(bus.br_type)) begin
          type_d    = b_t'(bus.br_type);
          target_d  = bus.br_target;
          tmo_cnt_d = '0;
          state_d   = StWaitAlu;
        end
      end
      StWaitAlu: begin
        if (bus.alu_valid) begin
          // alu_valid wins even on the cycle the timeout would expire.
          resolved_d   = 1'b1;
          b_taken_d    = cond_taken;
          branch_cnt_d = branch_cnt_q + CNT_W'(1);
          if (cond_taken) begin
            redirect_d  = 1'b1;
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
            flush_cnt_d = '0;
            state_d     = StFlush;
          end else begin
            state_d = StIdle;
          end
        end else if (tmo_cnt_q == TmoLast) begin
          timeout_err_d = 1'b1;
          resolved_d    = 1'b1;
          b_taken_d     = 1'b0;
          branch_cnt_d  = branch_cnt_q + CNT_W'(1);
          state_d       = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      StFlush: begin
        if (flush_cnt_q == FlushLast) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      type_q        <= BrNone;
      target_q      <= '0;
      tmo_cnt_q     <= '0;
      flush_cnt_q   <= '0;
      resolved_q    <= 1'b0;
      redirect_q    <= 1'b0;
      b_taken_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      target_q      <= target_d;
      tmo_cnt_q     <= tmo_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      resolved_q    <= resolved_d;
      redirect_q    <= redirect_d;
      b_taken_q     <= b_taken_d;
      timeout_err_q <= timeout_err_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign bus.br_ready       = (state_q == StIdle);
  assign bus.stall          = (state_q == StWaitAlu);
  assign bus.flush          = (state_q == StFlush);
  assign bus.redirect_valid = redirect_q;
  assign bus.redirect_pc    = target_q;
  assign bus.resolved       = resolved_q;
  assign bus.b_taken        = b_taken_q;
  assign bus.timeout_err    = timeout_err_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed vectors; expected results are queued when a branch
// is issued and a monitor pops/compares each resolved pulse.
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int unsigned FC = 2;
  localparam int unsigned WT = 8;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_ctrl_if #(.CNT_W(CW)) bus ();

  branch_ctrl #(
    .FLUSH_CYCLES (FC),
    .WAIT_TIMEOUT (WT),
    .CNT_W        (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          taken;
    bit          terr;
    logic [31:0] pc;
    logic [CW-1:0] bcnt;
    logic [CW-1:0] tcnt;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            failures = 0;
  bit            m_terr;
  logic [CW-1:0] m_bcnt;
  logic [CW-1:0] m_tcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic req);
    chk(name, {31'b0, act}, {31'b0, req});
  endtask

  // Monitor: every resolved pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.resolved) begin
      if (sb.size() == 0) begin
        chkb("unexpected_resolve", bus.resolved, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chkb("b_taken", bus.b_taken, mon_e.taken);
        chkb("redirect_valid", bus.redirect_valid, mon_e.taken);
        chkb("timeout_err", bus.timeout_err, mon_e.terr);
        chk("branch_cnt", 32'(bus.branch_cnt), 32'(mon_e.bcnt));
        chk("taken_cnt", 32'(bus.taken_cnt), 32'(mon_e.tcnt));
        if (mon_e.taken) chk("redirect_pc", bus.redirect_pc, mon_e.pc);
      end
    end
  end

  task automatic chk_reset(input string name);
    $display("reset check: %s", name);
    chkb("rst_br_ready", bus.br_ready, 1'b1);
    chkb("rst_stall", bus.stall, 1'b0);
    chkb("rst_flush", bus.flush, 1'b0);
    chkb("rst_redirect_valid", bus.redirect_valid, 1'b0);
    chkb("rst_resolved", bus.resolved, 1'b0);
    chkb("rst_b_taken", bus.b_taken, 1'b0);
    chkb("rst_timeout_err", bus.timeout_err, 1'b0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
    chk("rst_taken_cnt", 32'(bus.taken_cnt), 32'd0);
  endtask

  task automatic model_clear();
    sb.delete();
    m_terr = 1'b0;
    m_bcnt = '0;
    m_tcnt = '0;
  endtask

  task automatic push_exp(input bit taken, input logic [31:0] pc, input bit use_alu);
    exp_t e;
    m_bcnt = m_bcnt + 1'b1;
    if (use_alu && taken) m_tcnt = m_tcnt + 1'b1;
    if (!use_alu) m_terr = 1'b1;
    e.taken = use_alu && taken;
    e.terr  = m_terr;
    e.pc    = pc;
    e.bcnt  = m_bcnt;
    e.tcnt  = m_tcnt;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.br_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.br_ready) chkb("ready_wait_expired", bus.br_ready, 1'b1);
  endtask

  task automatic set_flags(input logic [3:0] f);
    {bus.ALU_neg_flag, bus.ALU_zero_flag, bus.ALU_overflow_flag, bus.ALU_borrow_flag} = f;
  endtask

  // f = {neg, zero, ovf, borrow}; gap = idle WAIT cycles before alu_valid.
  task automatic send(input b_t t, input logic [31:0] tgt, input int gap, input logic [3:0] f,
                      input bit use_alu, input bit exp_taken, input bit stale_flush);
    int n = 0;
    wait_ready();
    push_exp(exp_taken, tgt, use_alu);
    bus.br_valid  = 1'b1;
    bus.br_type   = t;
    bus.br_target = tgt;
    @(negedge clk);
    bus.br_valid = 1'b0;
    bus.br_type  = 3'd0;
    chkb("stall_after_accept", bus.stall, 1'b1);
    chkb("ready_low_in_wait", bus.br_ready, 1'b0);
    if (use_alu) begin
      repeat (gap) @(negedge clk);
      chkb("stall_held", bus.stall, 1'b1);
      set_flags(f);
      bus.alu_valid = 1'b1;
      @(negedge clk);
      bus.alu_valid = 1'b0;
      set_flags(4'b0000);
      if (exp_taken) begin
        chkb("stall_low_in_flush", bus.stall, 1'b0);
        while (bus.flush && n < 20) begin
          n++;
          if (stale_flush && n == 1) begin
            set_flags(4'b0100);
            bus.alu_valid = 1'b1;
          end
          @(negedge clk);
          bus.alu_valid = 1'b0;
          set_flags(4'b0000);
          if (n == 1) chkb("redirect_pulse_end", bus.redirect_valid, 1'b0);
        end
        chk("flush_cycles", n, FC);
        chkb("ready_after_flush", bus.br_ready, 1'b1);
      end else begin
        chkb("ready_after_not_taken", bus.br_ready, 1'b1);
        chkb("stall_after_not_taken", bus.stall, 1'b0);
        chkb("no_flush_not_taken", bus.flush, 1'b0);
      end
    end else begin
      repeat (WT) @(negedge clk);
      chkb("ready_after_timeout", bus.br_ready, 1'b1);
      chkb("stall_after_timeout", bus.stall, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.br_valid  = 1'b0;
    bus.br_type   = 3'd0;
    bus.br_target = 32'd0;
    bus.alu_valid = 1'b0;
    set_flags(4'b0000);
    model_clear();
    #12;
    chk_reset("power_on");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // f = {neg, zero, ovf, borrow}
    send(BrBeq,  32'h0000_1000, 1, 4'b0100, 1'b1, 1'b1, 1'b0);
    send(BrBlt,  32'h0000_2000, 0, 4'b1010, 1'b1, 1'b0, 1'b0);
    send(BrBge,  32'h0000_3000, 0, 4'b1010, 1'b1, 1'b1, 1'b0);
    send(BrBge,  32'h0000_4000, 2, 4'b0100, 1'b1, 1'b1, 1'b0);
    send(BrBgeu, 32'h0000_5000, 0, 4'b0000, 1'b1, 1'b1, 1'b0);
    send(BrBltu, 32'h0000_6000, 0, 4'b0001, 1'b1, 1'b1, 1'b0);
    send(BrBne,  32'h0000_7000, 0, 4'b0000, 1'b1, 1'b1, 1'b0);
    send(BrBne,  32'h0000_8000, 0, 4'b0100, 1'b1, 1'b0, 1'b0);
    send(BrBltu, 32'h0000_9000, 0, 4'b0000, 1'b1, 1'b0, 1'b0);
    send(BrBlt,  32'h0000_a000, 0, 4'b1000, 1'b1, 1'b1, 1'b0);
    send(BrBgeu, 32'h0000_b000, 0, 4'b0001, 1'b1, 1'b0, 1'b0);
    // alu_valid on the last allowed WAIT cycle: no error
    send(BrBeq,  32'h0000_c000, WT - 1, 4'b0000, 1'b1, 1'b0, 1'b0);
    chkb("no_err_on_last_cycle", bus.timeout_err, 1'b0);
    // stale alu_valid in FLUSH
    send(BrBeq,  32'h0000_d000, 0, 4'b0100, 1'b1, 1'b1, 1'b1);

    // stale alu_valid in IDLE
    set_flags(4'b0100);
    bus.alu_valid = 1'b1;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    set_flags(4'b0000);
    chkb("idle_alu_ready", bus.br_ready, 1'b1);
    chkb("idle_alu_stall", bus.stall, 1'b0);
    chk("idle_alu_bcnt", 32'(bus.branch_cnt), 32'(m_bcnt));

    // NONE and unused code 7 are consumed without effect
    bus.br_valid = 1'b1;
    bus.br_type  = 3'd0;
    @(negedge clk);
    chkb("none_ready", bus.br_ready, 1'b1);
    chkb("none_stall", bus.stall, 1'b0);
    bus.br_type = 3'd7;
    @(negedge clk);
    bus.br_valid = 1'b0;
    bus.br_type  = 3'd0;
    chkb("code7_ready", bus.br_ready, 1'b1);
    chkb("code7_stall", bus.stall, 1'b0);
    chk("none_bcnt", 32'(bus.branch_cnt), 32'(m_bcnt));
    chk("none_tcnt", 32'(bus.taken_cnt), 32'(m_tcnt));

    // timeout, then a taken branch still sees the sticky error
    send(BrBeq, 32'h0000_e000, 0, 4'b0000, 1'b0, 1'b0, 1'b0);
    send(BrBeq, 32'h0000_f000, 0, 4'b0100, 1'b1, 1'b1, 1'b0);
    chkb("timeout_sticky", bus.timeout_err, 1'b1);

    // async reset mid-WAIT_ALU
    wait_ready();
    bus.br_valid  = 1'b1;
    bus.br_type   = BrBne;
    bus.br_target = 32'h1234_5678;
    @(negedge clk);
    bus.br_valid = 1'b0;
    chkb("pre_rst_stall", bus.stall, 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset("mid_wait");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // async reset mid-FLUSH
    push_exp(1'b1, 32'h0bad_f00d, 1'b1);
    bus.br_valid  = 1'b1;
    bus.br_type   = BrBeq;
    bus.br_target = 32'h0bad_f00d;
    @(negedge clk);
    bus.br_valid = 1'b0;
    set_flags(4'b0100);
    bus.alu_valid = 1'b1;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    set_flags(4'b0000);
    chkb("pre_rst_flush", bus.flush, 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset("mid_flush");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 2^CNT_W resolves wrap branch_cnt to 0
    for (int i = 0; i < (1 << CW); i++) begin
      send(BrBne, 32'h100 + 32'(i), 0, 4'b0100, 1'b1, 1'b0, 1'b0);
    end
    chk("branch_cnt_wrap", 32'(bus.branch_cnt), 32'd0);
    chk("taken_cnt_after_wrap", 32'(bus.taken_cnt), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
